// File: rtl/i2s_frame_serdes_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | i2s_frame_serdes_pkg : shared constants and FSM states for the I2S  |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
package i2s_frame_serdes_pkg;

  localparam int DEF_TX_W    = 24;
  localparam int DEF_RX_W    = 16;
  localparam int DEF_SLOT_W  = 32;
  localparam int LOCK_FRAMES = 2;
  localparam int BIT_CNT_W   = 6;
  localparam int FRAME_CNT_W = 7;

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    CHECK  = 2'd1,
    LOCKED = 2'd2
  } state_t;

endpackage
`default_nettype wire

// File: rtl/i2s_edge_det.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | i2s_edge_det : one-cycle rise/fall pulses for a sampled level        |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module i2s_edge_det (
  input  logic clk,
  input  logic rst_n,
  input  logic sig,
  output logic rise,
  output logic fall
);

  logic sig_q;
  logic sig_d;

  always_comb begin
    sig_d = sig;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sig_q <= 1'b0;
    else        sig_q <= sig_d;
  end

  assign rise = sig & ~sig_q;
  assign fall = ~sig & sig_q;

endmodule
`default_nettype wire

// File: rtl/i2s_frame_serdes.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | i2s_frame_serdes : I2S slave framer, TX_W-bit out / RX_W-bit in     |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module i2s_frame_serdes
  import i2s_frame_serdes_pkg::*;
#(
  parameter int TX_W   = DEF_TX_W,
  parameter int RX_W   = DEF_RX_W,
  parameter int SLOT_W = DEF_SLOT_W
) (
  input  logic            SAICLK,
  input  logic            reset,
  input  logic            BCLK,
  input  logic            LRCLK,
  input  logic            DIN,
  output logic            DOUT,
  input  logic [TX_W-1:0] rx_real,
  input  logic [TX_W-1:0] rx_imag,
  input  logic            in_valid,
  output logic            in_ready,
  output logic [RX_W-1:0] tx_real,
  output logic [RX_W-1:0] tx_imag,
  output logic            out_valid,
  output logic            underrun,
  output logic            i2s_ok
);

  localparam int FRAME_BCLKS = 2 * SLOT_W;
  localparam logic [BIT_CNT_W-1:0]   CNT_ONE     = BIT_CNT_W'(1);
  localparam logic [BIT_CNT_W-1:0]   TX_BITS     = BIT_CNT_W'(TX_W);
  localparam logic [BIT_CNT_W-1:0]   RX_BITS     = BIT_CNT_W'(RX_W);
  localparam logic [BIT_CNT_W-1:0]   SLOT_RISES  = BIT_CNT_W'(SLOT_W);
  localparam logic [FRAME_CNT_W-1:0] FRM_ONE     = FRAME_CNT_W'(1);
  localparam logic [FRAME_CNT_W-1:0] FRAME_RISES = FRAME_CNT_W'(FRAME_BCLKS);
  localparam logic [FRAME_CNT_W-1:0] FRAME_LIMIT = FRAME_CNT_W'(FRAME_BCLKS + 2);
  localparam logic [1:0]             LOCK_LAST   = 2'(LOCK_FRAMES - 1);

  logic bclk_rise, bclk_fall, lr_rise, lr_fall;
  logic lr_edge, boundary, load, frame_good;

  state_t                 state_q, state_d;
  logic [1:0]             good_cnt_q, good_cnt_d;
  logic [BIT_CNT_W-1:0]   bit_cnt_q, bit_cnt_d, slot_rise_q, slot_rise_d;
  logic [FRAME_CNT_W-1:0] frame_rise_q, frame_rise_d;
  logic                   slot_bad_q, slot_bad_d;
  logic                   pend_full_q, pend_full_d;
  logic [TX_W-1:0]        pend_real_q, pend_real_d, pend_imag_q, pend_imag_d;
  logic [TX_W-1:0]        sh_real_q, sh_real_d, sh_imag_q, sh_imag_d;
  logic [RX_W-1:0]        cap_real_q, cap_real_d, cap_imag_q, cap_imag_d;
  logic [RX_W-1:0]        tx_real_q, tx_real_d, tx_imag_q, tx_imag_d;
  logic                   dout_q, dout_d, out_valid_q, out_valid_d, underrun_q, underrun_d;

  i2s_edge_det u_bclk_det (.clk(SAICLK), .rst_n(reset), .sig(BCLK),  .rise(bclk_rise), .fall(bclk_fall));
  i2s_edge_det u_lr_det   (.clk(SAICLK), .rst_n(reset), .sig(LRCLK), .rise(lr_rise),   .fall(lr_fall));

  assign lr_edge  = lr_rise | lr_fall;
  assign boundary = lr_fall;
  assign load     = in_valid & ~pend_full_q;

  always_comb begin
    pend_full_d = pend_full_q;
    pend_real_d = pend_real_q;
    pend_imag_d = pend_imag_q;
    sh_real_d   = sh_real_q;
    sh_imag_d   = sh_imag_q;
    cap_real_d  = cap_real_q;
    cap_imag_d  = cap_imag_q;
    underrun_d  = 1'b0;
    bit_cnt_d   = bit_cnt_q;
    dout_d      = dout_q;

    if (boundary) begin
      sh_real_d   = pend_full_q ? pend_real_q : '0;
      sh_imag_d   = pend_full_q ? pend_imag_q : '0;
      underrun_d  = ~pend_full_q;
      pend_full_d = 1'b0;
    end
    if (load) begin
      pend_full_d = 1'b1;
      pend_real_d = rx_real;
      pend_imag_d = rx_imag;
    end

    // The fall carrying the LRCLK change is index 0; falls 1..TX_W carry data MSB first.
    if (lr_edge) begin
      bit_cnt_d = '0;
      dout_d    = 1'b0;
    end else if (bclk_fall) begin
      if (bit_cnt_q != '1) bit_cnt_d = bit_cnt_q + CNT_ONE;
      dout_d = 1'b0;
      if (bit_cnt_q < TX_BITS) begin
        if (!LRCLK) begin
          dout_d    = sh_real_q[TX_W-1];
          sh_real_d = {sh_real_q[TX_W-2:0], 1'b0};
        end else begin
          dout_d    = sh_imag_q[TX_W-1];
          sh_imag_d = {sh_imag_q[TX_W-2:0], 1'b0};
        end
      end
    end
    if (state_q != LOCKED) dout_d = 1'b0;

    // Rise indexed by falls seen so far, so the MSB driven on fall 1 is caught on the next rise.
    if (bclk_rise && !lr_edge && bit_cnt_q != '0 && bit_cnt_q <= RX_BITS) begin
      if (!LRCLK) cap_real_d = {cap_real_q[RX_W-2:0], DIN};
      else        cap_imag_d = {cap_imag_q[RX_W-2:0], DIN};
    end
  end

  always_comb begin
    slot_rise_d  = slot_rise_q;
    frame_rise_d = frame_rise_q;
    slot_bad_d   = slot_bad_q;
    if (lr_edge)                                slot_rise_d = '0;
    else if (bclk_rise && slot_rise_q != '1)    slot_rise_d = slot_rise_q + CNT_ONE;
    if (boundary)                               frame_rise_d = '0;
    else if (bclk_rise && frame_rise_q != '1)   frame_rise_d = frame_rise_q + FRM_ONE;
    if (boundary)                               slot_bad_d = 1'b0;
    else if (lr_rise && slot_rise_q != SLOT_RISES) slot_bad_d = 1'b1;
  end

  assign frame_good = (frame_rise_q == FRAME_RISES) && (slot_rise_q == SLOT_RISES) && !slot_bad_q;

  always_comb begin
    state_d     = state_q;
    good_cnt_d  = good_cnt_q;
    out_valid_d = 1'b0;
    tx_real_d   = tx_real_q;
    tx_imag_d   = tx_imag_q;
    case (state_q)
      HUNT: begin
        if (boundary) begin
          state_d    = CHECK;
          good_cnt_d = '0;
        end
      end
      CHECK: begin
        if (boundary) begin
          if (!frame_good)                good_cnt_d = '0;
          else if (good_cnt_q == LOCK_LAST) state_d  = LOCKED;
          else                            good_cnt_d = good_cnt_q + 2'd1;
        end else if (frame_rise_q > FRAME_LIMIT) begin
          state_d = HUNT;
        end
      end
      LOCKED: begin
        if (boundary) begin
          if (frame_good) begin
            out_valid_d = 1'b1;
            tx_real_d   = cap_real_q;
            tx_imag_d   = cap_imag_q;
          end else begin
            state_d    = CHECK;
            good_cnt_d = '0;
          end
        end else if (frame_rise_q > FRAME_LIMIT) begin
          state_d = HUNT;
        end
      end
      default: state_d = HUNT;
    endcase
  end

  always_ff @(posedge SAICLK or negedge reset) begin
    if (!reset) begin
      state_q      <= HUNT;
      good_cnt_q   <= '0;
      bit_cnt_q    <= '0;
      slot_rise_q  <= '0;
      frame_rise_q <= '0;
      slot_bad_q   <= 1'b0;
      pend_full_q  <= 1'b0;
      pend_real_q  <= '0;
      pend_imag_q  <= '0;
      sh_real_q    <= '0;
      sh_imag_q    <= '0;
      cap_real_q   <= '0;
      cap_imag_q   <= '0;
      tx_real_q    <= '0;
      tx_imag_q    <= '0;
      dout_q       <= 1'b0;
      out_valid_q  <= 1'b0;
      underrun_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      good_cnt_q   <= good_cnt_d;
      bit_cnt_q    <= bit_cnt_d;
      slot_rise_q  <= slot_rise_d;
      frame_rise_q <= frame_rise_d;
      slot_bad_q   <= slot_bad_d;
      pend_full_q  <= pend_full_d;
      pend_real_q  <= pend_real_d;
      pend_imag_q  <= pend_imag_d;
      sh_real_q    <= sh_real_d;
      sh_imag_q    <= sh_imag_d;
      cap_real_q   <= cap_real_d;
      cap_imag_q   <= cap_imag_d;
      tx_real_q    <= tx_real_d;
      tx_imag_q    <= tx_imag_d;
      dout_q       <= dout_d;
      out_valid_q  <= out_valid_d;
      underrun_q   <= underrun_d;
    end
  end

  assign DOUT      = dout_q;
  assign in_ready  = ~pend_full_q;
  assign tx_real   = tx_real_q;
  assign tx_imag   = tx_imag_q;
  assign out_valid = out_valid_q;
  assign underrun  = underrun_q;
  assign i2s_ok    = (state_q == LOCKED);

endmodule
`default_nettype wire

// File: tb/tb_i2s_frame_serdes.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_i2s_frame_serdes : loopback bench for the I2S frame serdes       |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module tb_i2s_frame_serdes;

  logic        SAICLK = 1'b0;
  logic        reset = 1'b0;
  logic        BCLK = 1'b1;
  logic        LRCLK = 1'b0;
  logic        DIN;
  logic        DOUT;
  logic [23:0] rx_real = '0;
  logic [23:0] rx_imag = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] tx_real;
  logic [15:0] tx_imag;
  logic        out_valid;
  logic        underrun;
  logic        i2s_ok;

  int n_checks = 0;
  int n_err = 0;
  int ov_cnt = 0;
  int ur_cnt = 0;
  int dout_ones = 0;
  int ov0, ur0, d0;

  typedef struct {
    int          half;
    logic [23:0] re;
    logic [23:0] im;
    logic [15:0] exp_re;
    logic [15:0] exp_im;
  } vec_t;

  vec_t vecs [6];

  assign DIN = DOUT;

  i2s_frame_serdes dut (
    .SAICLK   (SAICLK),
    .reset    (reset),
    .BCLK     (BCLK),
    .LRCLK    (LRCLK),
    .DIN      (DIN),
    .DOUT     (DOUT),
    .rx_real  (rx_real),
    .rx_imag  (rx_imag),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .tx_real  (tx_real),
    .tx_imag  (tx_imag),
    .out_valid(out_valid),
    .underrun (underrun),
    .i2s_ok   (i2s_ok)
  );

  always #5 SAICLK = ~SAICLK;

  always @(negedge SAICLK) begin
    if (out_valid) ov_cnt++;
    if (underrun)  ur_cnt++;
    if (DOUT)      dout_ones++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge SAICLK);
    reset    = 1'b0;
    BCLK     = 1'b1;
    LRCLK    = 1'b0;
    in_valid = 1'b0;
    repeat (3) @(negedge SAICLK);
    reset = 1'b1;
    repeat (2) @(negedge SAICLK);
  endtask

  // One BCLK period per bit: fall (LRCLK changes here) then rise; drop suppresses one rise.
  task automatic run_bits(input int half, input int nbits, input int drop);
    for (int i = 0; i < nbits; i++) begin
      @(negedge SAICLK);
      BCLK  = 1'b0;
      LRCLK = (i >= 32);
      repeat (half - 1) @(negedge SAICLK);
      @(negedge SAICLK);
      BCLK = (i == drop) ? 1'b0 : 1'b1;
      repeat (half - 1) @(negedge SAICLK);
    end
  endtask

  task automatic run_frames(input int half, input int n);
    for (int f = 0; f < n; f++) run_bits(half, 64, -1);
  endtask

  initial begin
    vecs[0] = '{4, 24'h123456, 24'habcdef, 16'h1234, 16'habcd};
    vecs[1] = '{2, 24'h123456, 24'habcdef, 16'h1234, 16'habcd};
    vecs[2] = '{1, 24'h123456, 24'habcdef, 16'h1234, 16'habcd};
    vecs[3] = '{1, 24'h800001, 24'h7fffff, 16'h8000, 16'h7fff};
    vecs[4] = '{2, 24'hffffff, 24'h000000, 16'hffff, 16'h0000};
    vecs[5] = '{4, 24'h00ff00, 24'ha5a5a5, 16'h00ff, 16'ha5a5};

    repeat (3) @(negedge SAICLK);
    check("rst_dout", DOUT, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_tx_real", tx_real, 0);
    check("rst_tx_imag", tx_imag, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_underrun", underrun, 0);
    check("rst_i2s_ok", i2s_ok, 0);

    // Loopback at several rates and data patterns
    for (int v = 0; v < 6; v++) begin
      do_reset();
      rx_real  = vecs[v].re;
      rx_imag  = vecs[v].im;
      in_valid = 1'b1;
      ov0 = ov_cnt;
      run_frames(vecs[v].half, 3);
      check($sformatf("v%0d_not_locked", v), i2s_ok, 0);
      run_frames(vecs[v].half, 1);
      check($sformatf("v%0d_locked", v), i2s_ok, 1);
      check($sformatf("v%0d_no_ov_yet", v), ov_cnt - ov0, 0);
      run_frames(vecs[v].half, 1);
      check($sformatf("v%0d_tx_real", v), tx_real, vecs[v].exp_re);
      check($sformatf("v%0d_tx_imag", v), tx_imag, vecs[v].exp_im);
      check($sformatf("v%0d_ov_one", v), ov_cnt - ov0, 1);
      run_frames(vecs[v].half, 2);
      check($sformatf("v%0d_ov_per_frame", v), ov_cnt - ov0, 3);
      check($sformatf("v%0d_tx_real_hold", v), tx_real, vecs[v].exp_re);
    end

    // Underrun with no input, then a single load
    do_reset();
    ur0 = ur_cnt;
    d0  = dout_ones;
    ov0 = ov_cnt;
    run_frames(1, 5);
    check("ur_count", ur_cnt - ur0, 4);
    check("ur_dout_zero", dout_ones - d0, 0);
    check("ur_tx_zero", tx_real, 0);
    check("ur_ov", ov_cnt - ov0, 1);
    @(negedge SAICLK);
    rx_real  = 24'h654321;
    rx_imag  = 24'h0fedcb;
    in_valid = 1'b1;
    @(negedge SAICLK);
    in_valid = 1'b0;
    check("ld_in_ready_low", in_ready, 0);
    ur0 = ur_cnt;
    run_frames(1, 1);
    check("ld_in_ready_back", in_ready, 1);
    check("ld_no_underrun", ur_cnt - ur0, 0);
    run_frames(1, 1);
    check("ld_underrun_next", ur_cnt - ur0, 1);
    check("ld_tx_real", tx_real, 16'h6543);
    check("ld_tx_imag", tx_imag, 16'h0fed);
    run_frames(1, 1);
    check("ld_tx_real_zero", tx_real, 0);

    // New word presented at the boundary while the pending buffer is full
    do_reset();
    rx_real  = 24'h111111;
    rx_imag  = 24'h222222;
    in_valid = 1'b1;
    run_frames(1, 5);
    rx_real = 24'h333333;
    rx_imag = 24'h444444;
    check("bp_in_ready_full", in_ready, 0);
    run_frames(1, 2);
    check("bp_old_real", tx_real, 16'h1111);
    check("bp_old_imag", tx_imag, 16'h2222);
    run_frames(1, 1);
    check("bp_new_real", tx_real, 16'h3333);
    check("bp_new_imag", tx_imag, 16'h4444);

    // Dropped BCLK pulse breaks lock, then relock
    do_reset();
    rx_real  = 24'h5a5a5a;
    rx_imag  = 24'hc3c3c3;
    in_valid = 1'b1;
    run_frames(2, 5);
    check("drop_pre_lock", i2s_ok, 1);
    run_bits(2, 64, 10);
    ov0 = ov_cnt;
    run_frames(2, 1);
    check("drop_unlocked", i2s_ok, 0);
    check("drop_no_ov", ov_cnt - ov0, 0);
    run_frames(2, 1);
    check("drop_one_good", i2s_ok, 0);
    run_frames(2, 1);
    check("drop_relocked", i2s_ok, 1);
    run_frames(2, 1);
    check("drop_ov_after", ov_cnt - ov0, 1);
    check("drop_tx_real", tx_real, 16'h5a5a);
    check("drop_tx_imag", tx_imag, 16'hc3c3);

    // Asynchronous reset in the middle of a slot
    do_reset();
    rx_real  = 24'h123456;
    rx_imag  = 24'habcdef;
    in_valid = 1'b1;
    run_frames(1, 5);
    check("mr_pre_tx", tx_real, 16'h1234);
    run_bits(1, 20, -1);
    #3 reset = 1'b0;
    #1;
    check("mr_dout", DOUT, 0);
    check("mr_in_ready", in_ready, 1);
    check("mr_tx_real", tx_real, 0);
    check("mr_tx_imag", tx_imag, 0);
    check("mr_out_valid", out_valid, 0);
    check("mr_underrun", underrun, 0);
    check("mr_i2s_ok", i2s_ok, 0);
    do_reset();
    in_valid = 1'b1;
    run_frames(1, 5);
    check("mr_relock", i2s_ok, 1);
    check("mr_relock_real", tx_real, 16'h1234);
    check("mr_relock_imag", tx_imag, 16'habcd);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
`default_nettype wire
